// File: rtl/ipf_feeder.sv
// ipf_feeder: transmit-side driver for the IPF convolution engine.
// Streams weight and input-row words from a 64-bit SRAM into IPF's load
// interface, then sequences IPF's ctrl (START/HOLD/END) for a number of tiles.
// Optional feature: define IPF_FEEDER_PERF_EN to add the perf_cycles counter.
// The SRAM's own output register is the data register of the return path:
// rdata is valid the cycle after mem_ren, so w_data/i_data pass it straight
// through, gated by the registered strobe so they read zero when idle.
module ipf_feeder #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 64,
    parameter int ROWS_PER_TILE = 8,
    parameter int COMP_CYC      = 32,
    parameter int TILE_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            cfg_wsize,
    input  logic [ADDR_WIDTH-1:0] cfg_w_base,
    input  logic [ADDR_WIDTH-1:0] cfg_i_base,
    input  logic [TILE_WIDTH-1:0] cfg_tiles,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] i_data,
    output logic                  i_valid,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_valid,
    output logic [1:0]            ctrl,
    output logic [1:0]            Wsize,
    input  logic                  ipf_finish,
    output logic                  busy,
    output logic                  done
`ifdef IPF_FEEDER_PERF_EN
    ,
    output logic [31:0]           perf_cycles
`endif
);

    localparam logic [1:0] CTRL_END   = 2'd0;
    localparam logic [1:0] CTRL_START = 2'd1;
    localparam logic [1:0] CTRL_HOLD  = 2'd2;
    localparam int CNT_W = (ROWS_PER_TILE > 25) ? $clog2(ROWS_PER_TILE) + 1 : 5;
    localparam int RUN_W = $clog2(COMP_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOADW, ST_LOADI, ST_RUN, ST_HOLD, ST_ENDC, ST_WAITFIN, ST_DONE
    } state_t;

    // Weight words per tile; 7x7 alternates 25/24 to match IPF's weight carry-over.
    function automatic logic [CNT_W-1:0] nw_f(input logic [1:0] wsize, input logic odd_tile);
        logic [CNT_W-1:0] n;
        case (wsize)
            2'd0:    n = CNT_W'(5);
            2'd1:    n = CNT_W'(7);
            2'd2:    n = odd_tile ? CNT_W'(24) : CNT_W'(25);
            default: n = CNT_W'(5);
        endcase
        return n;
    endfunction

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RUN_W-1:0]      run_q, run_d;
    logic [TILE_WIDTH-1:0] tile_q, tile_d;
    logic [TILE_WIDTH-1:0] tiles_q, tiles_d;
    logic [1:0]            wsize_q, wsize_d;
    logic [ADDR_WIDTH-1:0] w_base_q, w_base_d;
    logic [ADDR_WIDTH-1:0] i_base_q, i_base_d;
    logic                  mem_ren_q, mem_ren_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  w_valid_q, w_valid_d;
    logic                  i_valid_q, i_valid_d;
    logic [1:0]            ctrl_q, ctrl_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [CNT_W-1:0]      nw_s;
    logic                  last_tile_s;
    logic [ADDR_WIDTH-1:0] tile_off_s;

    assign nw_s        = nw_f(wsize_q, tile_q[0]);
    assign last_tile_s = ({1'b0, tile_q} + (TILE_WIDTH+1)'(1)) == {1'b0, tiles_q};
    assign tile_off_s  = ADDR_WIDTH'(tile_d) * ADDR_WIDTH'(ROWS_PER_TILE);

    // Next-state, counters and configuration latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        tile_d   = tile_q;
        tiles_d  = tiles_q;
        wsize_d  = wsize_q;
        w_base_d = w_base_q;
        i_base_d = i_base_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tiles_d  = cfg_tiles;
                    wsize_d  = cfg_wsize;
                    w_base_d = cfg_w_base;
                    i_base_d = cfg_i_base;
                    tile_d   = {TILE_WIDTH{1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                    if (cfg_tiles != {TILE_WIDTH{1'b0}}) begin
                        state_d = ST_LOADW;
                    end else begin
                        state_d = ST_ENDC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOADW: begin
                if (cnt_q == nw_s - CNT_W'(1)) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_LOADI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOADI: begin
                if (cnt_q == CNT_W'(ROWS_PER_TILE - 1)) begin
                    cnt_d   = {CNT_W{1'b0}};
                    run_d   = {RUN_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // run_q==0 is the drain cycle carrying the last i_valid.
                if (run_q == RUN_W'(COMP_CYC)) begin
                    state_d = last_tile_s ? ST_ENDC : ST_HOLD;
                end else begin
                    run_d = run_q + RUN_W'(1);
                end
            end
            ST_HOLD: begin
                tile_d  = tile_q + TILE_WIDTH'(1);
                state_d = ST_LOADW;
            end
            ST_ENDC: begin
                state_d = ST_WAITFIN;
            end
            ST_WAITFIN: begin
                if (ipf_finish) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAITFIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs derived from the next state, so they line up with state_q.
    always_comb begin
        mem_ren_d  = 1'b0;
        mem_addr_d = {ADDR_WIDTH{1'b0}};
        ctrl_d     = CTRL_HOLD;
        case (state_d)
            ST_LOADW: begin
                mem_ren_d  = 1'b1;
                mem_addr_d = w_base_d + ADDR_WIDTH'(cnt_d);
            end
            ST_LOADI: begin
                mem_ren_d  = 1'b1;
                mem_addr_d = i_base_d + tile_off_s + ADDR_WIDTH'(cnt_d);
            end
            ST_RUN: begin
                if (run_d != {RUN_W{1'b0}}) begin
                    ctrl_d = CTRL_START;
                end else begin
                    ctrl_d = CTRL_HOLD;
                end
            end
            ST_ENDC, ST_WAITFIN: begin
                ctrl_d = CTRL_END;
            end
            default: begin
                ctrl_d = CTRL_HOLD;
            end
        endcase
        w_valid_d = mem_ren_q && (state_q == ST_LOADW);
        i_valid_d = mem_ren_q && (state_q == ST_LOADI);
        busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d    = (state_d == ST_DONE);
    end

    // State, counters, configuration and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            run_q      <= {RUN_W{1'b0}};
            tile_q     <= {TILE_WIDTH{1'b0}};
            tiles_q    <= {TILE_WIDTH{1'b0}};
            wsize_q    <= 2'd0;
            w_base_q   <= {ADDR_WIDTH{1'b0}};
            i_base_q   <= {ADDR_WIDTH{1'b0}};
            mem_ren_q  <= 1'b0;
            mem_addr_q <= {ADDR_WIDTH{1'b0}};
            w_valid_q  <= 1'b0;
            i_valid_q  <= 1'b0;
            ctrl_q     <= CTRL_HOLD;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            tile_q     <= tile_d;
            tiles_q    <= tiles_d;
            wsize_q    <= wsize_d;
            w_base_q   <= w_base_d;
            i_base_q   <= i_base_d;
            mem_ren_q  <= mem_ren_d;
            mem_addr_q <= mem_addr_d;
            w_valid_q  <= w_valid_d;
            i_valid_q  <= i_valid_d;
            ctrl_q     <= ctrl_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mem_ren  = mem_ren_q;
    assign mem_addr = mem_addr_q;
    assign w_valid  = w_valid_q;
    assign i_valid  = i_valid_q;
    assign w_data   = w_valid_q ? mem_rdata : {DATA_WIDTH{1'b0}};
    assign i_data   = i_valid_q ? mem_rdata : {DATA_WIDTH{1'b0}};
    assign ctrl     = ctrl_q;
    assign Wsize    = wsize_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef IPF_FEEDER_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle counter: cleared on an accepted start, saturating.
    always_comb begin
        perf_d = perf_q;
        if ((state_q == ST_IDLE) && start) begin
            perf_d = 32'd0;
        end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end else begin
            perf_d = perf_q;
        end
    end

    // Busy-cycle counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_ipf_feeder.sv
// Directed testbench for ipf_feeder with a 1-cycle-latency SRAM model.
module tb_ipf_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  cfg_wsize;
    logic [15:0] cfg_w_base;
    logic [15:0] cfg_i_base;
    logic [7:0]  cfg_tiles;
    logic        mem_ren;
    logic [15:0] mem_addr;
    logic [63:0] mem_rdata = 64'd0;
    logic [63:0] i_data;
    logic        i_valid;
    logic [63:0] w_data;
    logic        w_valid;
    logic [1:0]  ctrl;
    logic [1:0]  Wsize;
    logic        ipf_finish;
    logic        busy;
    logic        done;
`ifdef IPF_FEEDER_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ipf_feeder dut (
        .clk(clk), .rst(rst), .start(start), .cfg_wsize(cfg_wsize),
        .cfg_w_base(cfg_w_base), .cfg_i_base(cfg_i_base), .cfg_tiles(cfg_tiles),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .i_data(i_data), .i_valid(i_valid), .w_data(w_data), .w_valid(w_valid),
        .ctrl(ctrl), .Wsize(Wsize), .ipf_finish(ipf_finish), .busy(busy), .done(done)
`ifdef IPF_FEEDER_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    // SRAM model: data word tags its address; junk when not read.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= {32'hCAFE_F00D, 16'h0000, mem_addr};
        else         mem_rdata <= 64'h0BAD_0BAD_0BAD_0BAD;
    end

    logic [15:0] ren_log[$];
    logic [15:0] w_log[$];
    logic [15:0] i_log[$];
    int          runs[$];
    logic [1:0]  gaps[$];
    int overlap, run_activity, bad_data, end_cnt, done_cnt, fin_cyc, done_cyc;
    int first_w, last_w, first_i, last_i, first_start;
    int ctrl_after, done_after, busy_after;
    logic [1:0]  wsize_seen;
    logic [31:0] perf_at_done;

    task automatic run_job(input logic [1:0] ws, input logic [15:0] wb, input logic [15:0] ib,
                           input logic [7:0] nt, input int fin_delay, input int poke_cyc);
        int  run_len;
        bit  finished;
        ren_log.delete(); w_log.delete(); i_log.delete(); runs.delete(); gaps.delete();
        overlap = 0; run_activity = 0; bad_data = 0; end_cnt = 0; done_cnt = 0;
        fin_cyc = -1; done_cyc = -1; first_w = -1; last_w = -1; first_i = -1; last_i = -1;
        first_start = -1; ctrl_after = -1; done_after = -1; busy_after = -1;
        wsize_seen = 2'd3; perf_at_done = 32'd0; run_len = 0; finished = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; cfg_wsize = ws; cfg_w_base = wb; cfg_i_base = ib; cfg_tiles = nt;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            @(negedge clk);
            if (c == poke_cyc) begin
                start = 1'b1; cfg_w_base = 16'h0777; cfg_i_base = 16'h0999;
                cfg_tiles = 8'd9; cfg_wsize = 2'd2;
            end else begin
                start = 1'b0;
            end
            if (c == 2) wsize_seen = Wsize;
            if (mem_ren) ren_log.push_back(mem_addr);
            if (w_valid) begin
                w_log.push_back(w_data[15:0]);
                if (w_data[63:16] !== {32'hCAFE_F00D, 16'h0000}) bad_data++;
                if (first_w < 0) first_w = c;
                last_w = c;
            end
            if (i_valid) begin
                i_log.push_back(i_data[15:0]);
                if (i_data[63:16] !== {32'hCAFE_F00D, 16'h0000}) bad_data++;
                if (first_i < 0) first_i = c;
                last_i = c;
            end
            if (w_valid && i_valid) overlap++;
            if (ctrl == 2'd1) begin
                if (first_start < 0) first_start = c;
                run_len++;
                if (mem_ren || w_valid || i_valid) run_activity++;
            end else if (run_len != 0) begin
                runs.push_back(run_len);
                gaps.push_back(ctrl);
                run_len = 0;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
`ifdef IPF_FEEDER_PERF_EN
                perf_at_done = perf_cycles;
`endif
                @(negedge clk);
                ctrl_after = ctrl; done_after = done; busy_after = busy;
                finished = 1'b1;
            end else if (ctrl == 2'd0) begin
                end_cnt++;
                if (end_cnt >= fin_delay && fin_cyc < 0) begin
                    ipf_finish = 1'b1;
                    fin_cyc = c;
                end
            end
        end
        if (!finished) begin
            checks++; errors++;
            $display("FAIL job_timeout: done not seen, required done within 3000 cycles");
        end
        ipf_finish = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({mem_ren, w_valid, i_valid, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 00000", {mem_ren, w_valid, i_valid, busy, done});
        end
        checks++;
        if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h required 0000", mem_addr); end
        checks++;
        if ((w_data !== 64'd0) || (i_data !== 64'd0)) begin
            errors++; $display("FAIL reset_data: got w=%h i=%h required 0", w_data, i_data);
        end
        checks++;
        if (ctrl !== 2'd2) begin errors++; $display("FAIL reset_ctrl: got %0d required 2", ctrl); end
        checks++;
        if (Wsize !== 2'd0) begin errors++; $display("FAIL reset_wsize: got %0d required 0", Wsize); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ((ctrl !== 2'd2) || (busy !== 1'b0) || (mem_ren !== 1'b0)) begin
            errors++; $display("FAIL idle_after_reset: got ctrl=%0d busy=%b ren=%b required 2/0/0", ctrl, busy, mem_ren);
        end
    endtask

    task automatic test_single_3x3();
        logic [15:0] act;
        run_job(2'd0, 16'h0100, 16'h0200, 8'd1, 10, -1);
        checks++;
        if (ren_log.size() != 13) begin errors++; $display("FAIL s3_ren_count: got %0d required 13", ren_log.size()); end
        for (int k = 0; k < 13; k++) begin
            act = (k < ren_log.size()) ? ren_log[k] : 16'hxxxx;
            checks++;
            if (act !== ((k < 5) ? 16'h0100 + 16'(k) : 16'h0200 + 16'(k - 5))) begin
                errors++; $display("FAIL s3_addr[%0d]: got %h", k, act);
            end
        end
        checks++;
        if ((w_log.size() != 5) || (i_log.size() != 8) || (w_log[4] !== 16'h0104) || (i_log[7] !== 16'h0207)) begin
            errors++; $display("FAIL s3_strobes: got w=%0d i=%0d required 5/8 ending 0104/0207", w_log.size(), i_log.size());
        end
        checks++;
        if ((first_w != 1) || (last_w != 5) || (first_i != 6) || (last_i != 13)) begin
            errors++; $display("FAIL s3_timing: got w %0d-%0d i %0d-%0d required 1-5 6-13", first_w, last_w, first_i, last_i);
        end
        checks++;
        if ((runs.size() != 1) || (first_start != 14) || (runs[0] != 32)) begin
            errors++; $display("FAIL s3_run: got %0d runs first_start=%0d required 1 run of 32 at 14", runs.size(), first_start);
        end
        checks++;
        if ((end_cnt != 10) || (fin_cyc != 55) || (done_cyc != 56)) begin
            errors++; $display("FAIL s3_end: got end=%0d fin=%0d done=%0d required 10/55/56", end_cnt, fin_cyc, done_cyc);
        end
        checks++;
        if ((ctrl_after != 2) || (done_after != 0) || (busy_after != 0) || (done_cnt != 1)) begin
            errors++; $display("FAIL s3_post_done: got ctrl=%0d done=%0d busy=%0d required 2/0/0", ctrl_after, done_after, busy_after);
        end
        checks++;
        if ((overlap != 0) || (run_activity != 0) || (bad_data != 0) || (wsize_seen !== 2'd0)) begin
            errors++; $display("FAIL s3_clean: got ovl=%0d act=%0d bad=%0d ws=%0d required 0/0/0/0", overlap, run_activity, bad_data, wsize_seen);
        end
    endtask

    task automatic test_three_5x5();
        logic [15:0] act;
        run_job(2'd1, 16'h0300, 16'h0400, 8'd3, 3, 4);
        checks++;
        if (w_log.size() != 21) begin errors++; $display("FAIL t5_w_count: got %0d required 21", w_log.size()); end
        for (int k = 0; k < 21; k++) begin
            act = (k < w_log.size()) ? w_log[k] : 16'hxxxx;
            checks++;
            if (act !== 16'h0300 + 16'(k % 7)) begin errors++; $display("FAIL t5_w[%0d]: got %h", k, act); end
        end
        checks++;
        if (i_log.size() != 24) begin errors++; $display("FAIL t5_i_count: got %0d required 24", i_log.size()); end
        for (int k = 0; k < 24; k++) begin
            act = (k < i_log.size()) ? i_log[k] : 16'hxxxx;
            checks++;
            if (act !== 16'h0400 + 16'(k)) begin errors++; $display("FAIL t5_i[%0d]: got %h", k, act); end
        end
        checks++;
        if ((runs.size() != 3) || (runs[0] != 32) || (runs[1] != 32) || (runs[2] != 32)) begin
            errors++; $display("FAIL t5_runs: got %0d runs required 3 of 32", runs.size());
        end
        checks++;
        if ((gaps.size() != 3) || (gaps[0] !== 2'd2) || (gaps[1] !== 2'd2) || (gaps[2] !== 2'd0)) begin
            errors++; $display("FAIL t5_gaps: got %0d gaps required HOLD,HOLD,END", gaps.size());
        end
        checks++;
        if ((end_cnt != 3) || (done_cyc != fin_cyc + 1) || (wsize_seen !== 2'd1) || (overlap != 0)) begin
            errors++; $display("FAIL t5_end: got end=%0d fin=%0d done=%0d ws=%0d required 3/done=fin+1/1", end_cnt, fin_cyc, done_cyc, wsize_seen);
        end
    endtask

    task automatic test_7x7_wrap();
        logic [15:0] exp_q[$];
        logic [15:0] act;
        for (int k = 0; k < 25; k++) exp_q.push_back(16'hFFF0 + 16'(k));
        for (int k = 0; k < 8;  k++) exp_q.push_back(16'hFFFC + 16'(k));
        for (int k = 0; k < 24; k++) exp_q.push_back(16'hFFF0 + 16'(k));
        for (int k = 8; k < 16; k++) exp_q.push_back(16'hFFFC + 16'(k));
        run_job(2'd2, 16'hFFF0, 16'hFFFC, 8'd2, 1, -1);
        checks++;
        if (ren_log.size() != 65) begin errors++; $display("FAIL w7_ren_count: got %0d required 65", ren_log.size()); end
        for (int k = 0; k < 65; k++) begin
            act = (k < ren_log.size()) ? ren_log[k] : 16'hxxxx;
            checks++;
            if (act !== exp_q[k]) begin errors++; $display("FAIL w7_addr[%0d]: got %h required %h", k, act, exp_q[k]); end
        end
        checks++;
        if ((w_log.size() != 49) || (i_log.size() != 16) || (overlap != 0) || (runs.size() != 2)) begin
            errors++; $display("FAIL w7_summary: got w=%0d i=%0d ovl=%0d runs=%0d required 49/16/0/2", w_log.size(), i_log.size(), overlap, runs.size());
        end
        checks++;
        if ((end_cnt != 2) || (done_cyc != fin_cyc + 2)) begin
            errors++; $display("FAIL w7_end: got end=%0d fin=%0d done=%0d required 2 and done=fin+2", end_cnt, fin_cyc, done_cyc);
        end
    endtask

    task automatic test_zero_tiles();
        run_job(2'd0, 16'h0100, 16'h0200, 8'd0, 1, -1);
        checks++;
        if ((ren_log.size() != 0) || (w_log.size() != 0) || (i_log.size() != 0) || (runs.size() != 0)) begin
            errors++; $display("FAIL z_activity: got ren=%0d runs=%0d required 0/0", ren_log.size(), runs.size());
        end
        checks++;
        if ((end_cnt != 2) || (fin_cyc != 0) || (done_cyc != 2) || (done_cnt != 1)) begin
            errors++; $display("FAIL z_end: got end=%0d fin=%0d done=%0d required 2/0/2", end_cnt, fin_cyc, done_cyc);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        int strobes;
        seen = 0; strobes = 0;
        @(posedge clk); #1;
        start = 1'b1; cfg_wsize = 2'd0; cfg_w_base = 16'h0100; cfg_i_base = 16'h0200; cfg_tiles = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 100 && seen < 3; c++) begin
            @(negedge clk);
            if (i_valid) seen++;
        end
        checks++;
        if (seen != 3) begin errors++; $display("FAIL rm_wait: got %0d i_valid required 3", seen); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({mem_ren, w_valid, i_valid, busy, done} !== 5'b0 || (i_data !== 64'd0) || (ctrl !== 2'd2) || (mem_addr !== 16'h0)) begin
            errors++; $display("FAIL rm_async: got strobes=%b ctrl=%0d addr=%h required 0/2/0", {mem_ren, w_valid, i_valid, busy, done}, ctrl, mem_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (mem_ren || w_valid || i_valid || busy) strobes++;
        end
        checks++;
        if (strobes != 0) begin errors++; $display("FAIL rm_quiet: got %0d active cycles required 0", strobes); end
        run_job(2'd0, 16'h0500, 16'h0600, 8'd1, 2, -1);
        checks++;
        if ((ren_log.size() != 13) || (ren_log[0] !== 16'h0500) || (w_log[0] !== 16'h0500) || (i_log[0] !== 16'h0600) || (done_cnt != 1)) begin
            errors++; $display("FAIL rm_restart: got ren=%0d first=%h required 13 starting 0500", ren_log.size(), ren_log[0]);
        end
    endtask

`ifdef IPF_FEEDER_PERF_EN
    task automatic test_perf();
        run_job(2'd0, 16'h0100, 16'h0200, 8'd1, 1, -1);
        checks++;
        if (perf_at_done !== 32'd48) begin errors++; $display("FAIL perf_done: got %0d required 48", perf_at_done); end
        repeat (3) @(negedge clk);
        checks++;
        if (perf_cycles !== 32'd48) begin errors++; $display("FAIL perf_hold: got %0d required 48", perf_cycles); end
    endtask
`endif

    initial begin
        rst = 1'b0; start = 1'b0; cfg_wsize = 2'd0; cfg_w_base = 16'h0;
        cfg_i_base = 16'h0; cfg_tiles = 8'd0; ipf_finish = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_single_3x3();
        test_three_5x5();
        test_7x7_wrap();
        test_zero_tiles();
        test_reset_mid();
`ifdef IPF_FEEDER_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
